// File: rtl/sccb_init_seq.sv
// sccb_init_seq: walks a camera register table held in an external synchronous ROM and
// issues SCCB writes, with optional read-back verify, bounded retry, delay entries and timeout.
module sccb_init_seq #(
    parameter int ROM_AW         = 6,
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 8,
    parameter int PWRUP_CYCLES   = 1000,
    parameter int GAP_CYCLES     = 16,
    parameter int DELAY_UNIT     = 1000,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int MAX_RETRY      = 3,
    parameter bit VERIFY_EN      = 1'b1
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  start,
    input  logic [ROM_AW:0]       rom_entries,
    output logic [ROM_AW-1:0]     rom_addr,
    input  logic [16:0]           rom_data,
    output logic                  sccb_valid,
    output logic                  sccb_rnw,
    output logic [ADDR_WIDTH-1:0] sccb_addr,
    output logic [DATA_WIDTH-1:0] sccb_wdata,
    input  logic                  sccb_done,
    input  logic [DATA_WIDTH-1:0] sccb_rdata,
    output logic                  busy,
    output logic                  init_done,
    output logic                  init_error,
    output logic [ROM_AW-1:0]     err_index
);

    typedef enum logic [3:0] {
        S_IDLE, S_PWRUP, S_FETCH, S_LATCH, S_ISSUE, S_WAIT,
        S_CHECK, S_GAP, S_DELAY, S_NEXT, S_DONE, S_ERROR
    } state_t;

    localparam logic [31:0] PWRUP_LAST   = 32'(PWRUP_CYCLES - 1);
    localparam logic [31:0] GAP_LAST     = 32'(GAP_CYCLES - 1);
    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0] DLY_UNIT     = 32'(DELAY_UNIT);
    localparam logic [31:0] RETRY_MAX    = 32'(MAX_RETRY);
    localparam logic [ROM_AW:0] IDX_ONE  = 1;

    state_t              state;
    logic [ROM_AW:0]     index;
    logic [ROM_AW:0]     entries_q;
    logic [ROM_AW:0]     index_nxt;
    logic [31:0]         cnt;
    logic [31:0]         retry_cnt;
    logic                ent_skip;
    logic [7:0]          ent_addr;
    logic [7:0]          ent_data;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                do_read;
    logic                gap_issue;

    // The ROM address simply follows the table index, so it is stable through FETCH.
    assign rom_addr  = index[ROM_AW-1:0];
    assign index_nxt = index + IDX_ONE;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= S_IDLE;
            busy       <= 1'b0;
            init_done  <= 1'b0;
            init_error <= 1'b0;
            sccb_valid <= 1'b0;
            sccb_rnw   <= 1'b0;
            sccb_addr  <= '0;
            sccb_wdata <= '0;
            err_index  <= '0;
            index      <= '0;
            entries_q  <= '0;
            cnt        <= '0;
            retry_cnt  <= '0;
            ent_skip   <= 1'b0;
            ent_addr   <= '0;
            ent_data   <= '0;
            rdata_q    <= '0;
            do_read    <= 1'b0;
            gap_issue  <= 1'b0;
        end else begin
            sccb_valid <= 1'b0;
            case (state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start) begin
                        init_done  <= 1'b0;
                        init_error <= 1'b0;
                        busy       <= 1'b1;
                        index      <= '0;
                        retry_cnt  <= '0;
                        entries_q  <= rom_entries;
                        cnt        <= '0;
                        state      <= S_PWRUP;
                    end else if (state == S_DONE) begin
                        init_done <= 1'b1;
                        busy      <= 1'b0;
                    end else if (state == S_ERROR) begin
                        init_error <= 1'b1;
                        busy       <= 1'b0;
                        err_index  <= index[ROM_AW-1:0];
                    end
                end
                S_PWRUP: begin
                    if (cnt == PWRUP_LAST) begin
                        cnt   <= '0;
                        state <= (entries_q == '0) ? S_DONE : S_FETCH;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                S_FETCH: state <= S_LATCH;
                S_LATCH: begin
                    ent_skip <= rom_data[16];
                    ent_addr <= rom_data[15:8];
                    ent_data <= rom_data[7:0];
                    do_read  <= 1'b0;
                    // Register address 0xFF marks a delay entry; its data is the delay in units.
                    if (rom_data[15:8] == 8'hFF) begin
                        if (rom_data[7:0] == 8'h00) begin
                            state <= S_NEXT;
                        end else begin
                            cnt   <= 32'(rom_data[7:0]) * DLY_UNIT;
                            state <= S_DELAY;
                        end
                    end else begin
                        state <= S_ISSUE;
                    end
                end
                S_DELAY: begin
                    if (cnt <= 32'd1) begin
                        cnt   <= '0;
                        state <= S_NEXT;
                    end else begin
                        cnt <= cnt - 32'd1;
                    end
                end
                S_ISSUE: begin
                    sccb_valid <= 1'b1;
                    sccb_rnw   <= do_read;
                    sccb_addr  <= ADDR_WIDTH'(ent_addr);
                    sccb_wdata <= DATA_WIDTH'(ent_data);
                    cnt        <= 32'd1;
                    state      <= S_WAIT;
                end
                S_WAIT: begin
                    if (sccb_done) begin
                        cnt <= '0;
                        if (sccb_rnw) begin
                            rdata_q <= sccb_rdata;
                            state   <= S_CHECK;
                        end else begin
                            state <= S_GAP;
                            if (VERIFY_EN && !ent_skip) begin
                                do_read   <= 1'b1;
                                gap_issue <= 1'b1;
                            end else begin
                                gap_issue <= 1'b0;
                            end
                        end
                    end else if (cnt == TIMEOUT_LAST) begin
                        state <= S_ERROR;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                S_CHECK: begin
                    cnt   <= '0;
                    state <= S_GAP;
                    if (rdata_q == DATA_WIDTH'(ent_data)) begin
                        gap_issue <= 1'b0;
                    end else if (retry_cnt < RETRY_MAX) begin
                        retry_cnt <= retry_cnt + 32'd1;
                        do_read   <= 1'b0;
                        gap_issue <= 1'b1;
                    end else begin
                        state <= S_ERROR;
                    end
                end
                S_GAP: begin
                    if (cnt == GAP_LAST) begin
                        cnt   <= '0;
                        state <= gap_issue ? S_ISSUE : S_NEXT;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                S_NEXT: begin
                    retry_cnt <= '0;
                    index     <= index_nxt;
                    state     <= (index_nxt == entries_q) ? S_DONE : S_FETCH;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sccb_init_seq.sv
// tb_sccb_init_seq: scoreboard bench for sccb_init_seq with a synchronous ROM, a behavioural
// sccb_fsm responder and a table-level reference model of the expected command stream.
`timescale 1ns/1ps
module tb_sccb_init_seq;

    localparam int ROM_AW = 6;
    localparam int PWRUP  = 10;
    localparam int GAP    = 16;
    localparam int DUNIT  = 1000;
    localparam int TMO    = 4096;
    localparam int MAXR   = 3;
    localparam bit VERIFY = 1'b1;

    typedef struct packed {
        logic       rnw;
        logic [7:0] addr;
        logic [7:0] wdata;
    } cmd_t;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic              start = 1'b0;
    logic [ROM_AW:0]   rom_entries = '0;
    logic [ROM_AW-1:0] rom_addr;
    logic [16:0]       rom_data = '0;
    logic              sccb_valid;
    logic              sccb_rnw;
    logic [7:0]        sccb_addr;
    logic [7:0]        sccb_wdata;
    logic              sccb_done = 1'b0;
    logic [7:0]        sccb_rdata = '0;
    logic              busy;
    logic              init_done;
    logic              init_error;
    logic [ROM_AW-1:0] err_index;

    logic [16:0] rom [0:63];
    logic [7:0]  slave_mem [0:255];
    int          bad_cnt [0:255];
    int          resp_lat = 100;
    bit          no_done = 1'b0;
    cmd_t        exp_q[$];
    int          valid_cycle[$];
    int          n_checks = 0;
    int          n_fails = 0;
    int          cycle = 0;
    int          valid_cnt = 0;
    int          start_cycle = 0;
    int          end_cycle = 0;

    sccb_init_seq #(
        .ROM_AW(ROM_AW), .DATA_WIDTH(8), .ADDR_WIDTH(8), .PWRUP_CYCLES(PWRUP),
        .GAP_CYCLES(GAP), .DELAY_UNIT(DUNIT), .TIMEOUT_CYCLES(TMO),
        .MAX_RETRY(MAXR), .VERIFY_EN(VERIFY)
    ) dut (
        .clk(clk), .rstn(rstn), .start(start), .rom_entries(rom_entries),
        .rom_addr(rom_addr), .rom_data(rom_data), .sccb_valid(sccb_valid),
        .sccb_rnw(sccb_rnw), .sccb_addr(sccb_addr), .sccb_wdata(sccb_wdata),
        .sccb_done(sccb_done), .sccb_rdata(sccb_rdata), .busy(busy),
        .init_done(init_done), .init_error(init_error), .err_index(err_index)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;
    always @(posedge clk) rom_data <= rom[rom_addr];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    // Responder: acknowledges each command after resp_lat cycles; reads of an address with a
    // nonzero bad count return the stored byte with bit 0 flipped.
    initial begin
        forever begin
            @(negedge clk);
            if (sccb_valid && !no_done) begin
                automatic logic       rnw = sccb_rnw;
                automatic logic [7:0] a   = sccb_addr;
                automatic logic [7:0] wd  = sccb_wdata;
                repeat (resp_lat - 1) @(negedge clk);
                if (rnw) begin
                    sccb_rdata = slave_mem[a];
                    if (bad_cnt[a] > 0) begin
                        sccb_rdata = slave_mem[a] ^ 8'h01;
                        bad_cnt[a]--;
                    end
                end else begin
                    slave_mem[a] = wd;
                end
                sccb_done = 1'b1;
                @(negedge clk);
                sccb_done = 1'b0;
            end
        end
    end

    // Monitor: pops the scoreboard on every command and checks pulse width and field stability.
    initial begin
        logic        prev_valid = 1'b0;
        logic        holding = 1'b0;
        logic [16:0] held = '0;
        cmd_t        cur;
        cmd_t        e;
        forever begin
            @(negedge clk);
            if (!busy) holding = 1'b0;
            if (sccb_valid) begin
                checkOutput("valid_pulse_width", {31'd0, prev_valid}, 32'd0);
                valid_cnt++;
                valid_cycle.push_back(cycle);
                cur = '{sccb_rnw, sccb_addr, sccb_rnw ? 8'h00 : sccb_wdata};
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fails++;
                    $display("[TB] FAIL unexpected_cmd: got 0x%0h, expected no command (cycle %0d)", cur, cycle);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("cmd", 32'(cur), 32'(e));
                end
                held = {sccb_rnw, sccb_addr, sccb_wdata};
                holding = 1'b1;
            end
            if (sccb_done && holding) begin
                checkOutput("cmd_stable", 32'({sccb_rnw, sccb_addr, sccb_wdata}), 32'(held));
                holding = 1'b0;
            end
            prev_valid = sccb_valid;
        end
    end

    initial begin
        repeat (95000) @(posedge clk);
        $display("[TB] FAIL watchdog: simulation exceeded cycle budget");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic setEntry(input int i, input bit skip, input logic [7:0] a, input logic [7:0] d);
        rom[i] = {skip, a, d};
    endtask

    task automatic clearTable();
        for (int i = 0; i < 64; i++) rom[i] = '0;
        for (int a = 0; a < 256; a++) bad_cnt[a] = 0;
    endtask

    // Reference model: each entry yields a write, plus a read when verified; a bad read costs one
    // retry, and a bad read after MAX_RETRY retries aborts at that entry.
    task automatic buildExpected(input int n, input bit tmo_mode, output bit exp_err, output int exp_idx);
        int bad [0:255];
        exp_q.delete();
        for (int a = 0; a < 256; a++) bad[a] = bad_cnt[a];
        exp_err = 1'b0;
        exp_idx = 0;
        for (int i = 0; i < n; i++) begin
            automatic logic [16:0] e = rom[i];
            if (e[15:8] == 8'hFF) continue;
            if (tmo_mode) begin
                exp_q.push_back(cmd_t'{1'b0, e[15:8], e[7:0]});
                exp_err = 1'b1;
                exp_idx = i;
                return;
            end
            for (int att = 0; att <= MAXR; att++) begin
                exp_q.push_back(cmd_t'{1'b0, e[15:8], e[7:0]});
                if (!VERIFY || e[16]) break;
                exp_q.push_back(cmd_t'{1'b1, e[15:8], 8'h00});
                if (bad[e[15:8]] == 0) break;
                bad[e[15:8]]--;
                if (att == MAXR) begin
                    exp_err = 1'b1;
                    exp_idx = i;
                    return;
                end
            end
        end
    endtask

    task automatic applyStimulus(input int n);
        valid_cnt = 0;
        valid_cycle.delete();
        @(negedge clk);
        rom_entries = (ROM_AW + 1)'(n);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        start_cycle = cycle;
    endtask

    task automatic waitEnd(input int budget);
        bit ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (init_done || init_error) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        end_cycle = cycle;
        if (!ok) begin
            n_checks++;
            n_fails++;
            $display("[TB] FAIL end_wait: busy=%0b after %0d cycles, expected init_done or init_error", busy, budget);
        end
    endtask

    task automatic finalChecks(input string name, input bit exp_err, input int exp_idx);
        $display("[TB] %s: %0d commands observed", name, valid_cnt);
        checkOutput("pending_cmds", 32'(exp_q.size()), 32'd0);
        checkOutput("init_done", {31'd0, init_done}, {31'd0, !exp_err});
        checkOutput("init_error", {31'd0, init_error}, {31'd0, exp_err});
        checkOutput("busy_end", {31'd0, busy}, 32'd0);
        if (exp_err) checkOutput("err_index", 32'(err_index), 32'(exp_idx));
    endtask

    task automatic runScenario(input string name, input int n, input bit tmo_mode, input int budget);
        bit exp_err;
        int exp_idx;
        buildExpected(n, tmo_mode, exp_err, exp_idx);
        applyStimulus(n);
        waitEnd(budget);
        finalChecks(name, exp_err, exp_idx);
    endtask

    task automatic loadBaseTable();
        clearTable();
        setEntry(0, 1'b1, 8'h12, 8'h80);
        setEntry(1, 1'b0, 8'hFF, 8'h02);
        setEntry(2, 1'b0, 8'h11, 8'h01);
    endtask

    initial begin
        bit exp_err;
        int exp_idx;
        clearTable();
        for (int a = 0; a < 256; a++) slave_mem[a] = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset_busy", {31'd0, busy}, 32'd0);
        checkOutput("reset_valid", {31'd0, sccb_valid}, 32'd0);
        checkOutput("reset_flags", {30'd0, init_done, init_error}, 32'd0);
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        // Base table; a start pulse in the middle of the delay must be ignored.
        loadBaseTable();
        resp_lat = 100;
        buildExpected(3, 1'b0, exp_err, exp_idx);
        applyStimulus(3);
        repeat (500) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("busy_after_restart", {31'd0, busy}, 32'd1);
        waitEnd(20000);
        finalChecks("base", exp_err, exp_idx);
        checkOutput("base_valid_count", 32'(valid_cnt), 32'd3);
        checkOutput("delay_gap_ok", {31'd0, (valid_cnt >= 2) && (valid_cycle[1] - valid_cycle[0] >= 2000)}, 32'd1);

        loadBaseTable();
        bad_cnt[8'h11] = 100;
        runScenario("retry_exhausted", 3, 1'b0, 20000);
        checkOutput("retry_valid_count", 32'(valid_cnt), 32'd9);
        checkOutput("retry_err_index", 32'(err_index), 32'd2);

        loadBaseTable();
        bad_cnt[8'h11] = 1;
        runScenario("retry_once", 3, 1'b0, 20000);
        checkOutput("retry_once_valid_count", 32'(valid_cnt), 32'd5);

        clearTable();
        runScenario("empty_table", 0, 1'b0, 1000);
        checkOutput("empty_done_latency", 32'(end_cycle - start_cycle), 32'(PWRUP + 1));
        checkOutput("empty_valid_count", 32'(valid_cnt), 32'd0);

        clearTable();
        setEntry(0, 1'b0, 8'hFF, 8'h00);
        setEntry(1, 1'b0, 8'h20, 8'h55);
        no_done = 1'b1;
        runScenario("timeout", 2, 1'b1, 10000);
        checkOutput("timeout_latency", 32'(end_cycle - ((valid_cycle.size() > 0) ? valid_cycle[0] : 0)), 32'(TMO));
        no_done = 1'b0;

        // Reset while waiting for the first acknowledge, then rerun from index 0.
        loadBaseTable();
        resp_lat = 100;
        buildExpected(3, 1'b0, exp_err, exp_idx);
        applyStimulus(3);
        for (int i = 0; i < 300 && valid_cnt == 0; i++) @(negedge clk);
        checkOutput("reset_run_started", {31'd0, valid_cnt > 0}, 32'd1);
        repeat (20) @(negedge clk);
        rstn = 1'b0;
        #1;
        checkOutput("midrun_reset_ctrl", {27'd0, busy, init_done, init_error, sccb_valid, sccb_rnw}, 32'd0);
        checkOutput("midrun_reset_bus", {16'd0, sccb_addr, sccb_wdata}, 32'd0);
        checkOutput("midrun_reset_idx", {20'd0, rom_addr, err_index}, 32'd0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        repeat (200) @(negedge clk);
        runScenario("after_reset", 3, 1'b0, 20000);

        for (int s = 0; s < 5; s++) begin
            automatic int n = $urandom_range(1, 8);
            clearTable();
            resp_lat = $urandom_range(3, 40);
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 5) == 0)
                    setEntry(i, 1'($urandom_range(0, 1)), 8'hFF, 8'($urandom_range(0, 1)));
                else
                    setEntry(i, 1'($urandom_range(0, 1)), 8'($urandom_range(16, 31)), 8'($urandom));
            end
            bad_cnt[$urandom_range(16, 31)] = $urandom_range(0, 4);
            runScenario("random", n, 1'b0, 30000);
        end

        // Full table: the index must reach 2^ROM_AW without wrapping.
        clearTable();
        resp_lat = 3;
        for (int i = 0; i < 64; i++) setEntry(i, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 254)), 8'($urandom));
        runScenario("full_table", 64, 1'b0, 30000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/sccb_init_seq.md
Name: sccb_init_seq

Overview:
- Upstream command source for sccb_fsm. After power-up it walks a camera configuration table of (register address, data, flags) entries held in an external synchronous ROM and issues one SCCB write per entry.
- Each write can optionally be read back and compared, with bounded retry on mismatch.
- Supports timed delay entries, for example after the OV7725 soft reset.
- Reports completion or failure to the system controller.

Parameters:
- ROM_AW, 6, ROM address width; maximum table size is 2^ROM_AW entries.
- DATA_WIDTH, 8, register data width.
- ADDR_WIDTH, 8, register address width.
- PWRUP_CYCLES, 1000, clk cycles to wait after start before the first command.
- GAP_CYCLES, 16, idle clk cycles between sccb_done and the next sccb_valid; minimum 2.
- DELAY_UNIT, 1000, clk cycles per unit of a delay entry.
- TIMEOUT_CYCLES, 4096, maximum clk cycles from sccb_valid to sccb_done.
- MAX_RETRY, 3, additional write attempts allowed after a verify mismatch.
- VERIFY_EN, 1, global read-back enable.

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- start  in  1  single-cycle pulse; begins the init sequence
- rom_entries  in  ROM_AW+1  number of valid table entries; sampled at start
- rom_addr  out  ROM_AW  table index
- rom_data  in  17  entry {skip_verify, reg_addr[7:0], reg_data[7:0]}; valid 1 cycle after rom_addr
- sccb_valid  out  1  one-cycle command pulse to sccb_fsm valid_in
- sccb_rnw  out  1  to sccb_fsm write input; 1 = read, 0 = write
- sccb_addr  out  ADDR_WIDTH  register address
- sccb_wdata  out  DATA_WIDTH  write data
- sccb_done  in  1  one-cycle transaction-complete pulse from sccb_fsm
- sccb_rdata  in  DATA_WIDTH  read data; valid when sccb_done pulses after a read
- busy  out  1  high from start until DONE or ERROR
- init_done  out  1  sticky; sequence completed without error
- init_error  out  1  sticky; sequence aborted
- err_index  out  ROM_AW  index of the failing entry

Behaviour:
- Reset (async, any state): state IDLE. busy, init_done, init_error, sccb_valid and sccb_rnw are 0. rom_addr, sccb_addr, sccb_wdata and err_index are 0. All counters are 0.
- States: IDLE, PWRUP, FETCH, LATCH, ISSUE, WAIT, CHECK, GAP, DELAY, NEXT, DONE, ERROR.
- IDLE/DONE/ERROR with start=1 → PWRUP on the next edge.
  - Clears init_done, init_error, index and retry count.
  - Latches rom_entries; sets busy.
  - start is ignored in every other state.
- PWRUP counts PWRUP_CYCLES cycles.
  - If latched entries == 0 → DONE; otherwise → FETCH.
- FETCH drives rom_addr = index for one cycle → LATCH.
- LATCH captures rom_data into the entry register.
  - reg_addr == 8'hFF is a delay entry: load delay count = reg_data*DELAY_UNIT → DELAY. reg_data == 0 gives zero delay (straight to NEXT).
  - Any other reg_addr → ISSUE (write).
- DELAY decrements to 0 → NEXT. Delay entries are never verified.
- ISSUE asserts sccb_valid for exactly 1 cycle and drives the SCCB fields:
  - write: sccb_rnw=0, sccb_addr=reg_addr, sccb_wdata=reg_data.
  - read-back: sccb_rnw=1, same sccb_addr.
  - sccb_addr, sccb_wdata and sccb_rnw stay stable from ISSUE until sccb_done.
  - Next state → WAIT.
- WAIT waits for sccb_done, with a timeout counter started at ISSUE.
  - Count reaching TIMEOUT_CYCLES → ERROR.
  - After a write: go to GAP, then to read-back ISSUE if VERIFY_EN=1 and skip_verify=0, else to NEXT.
  - After a read: capture sccb_rdata and go to CHECK.
- CHECK compares the captured read data with reg_data.
  - Match → GAP → NEXT.
  - Mismatch with retry count < MAX_RETRY → increment retry, GAP, then re-issue the write.
  - Mismatch with retry count == MAX_RETRY → ERROR.
- GAP holds GAP_CYCLES cycles before any ISSUE or NEXT.
  - This guarantees sccb_valid is never coincident with sccb_done and that sccb_fsm is back in its idle state.
- NEXT clears the retry count and increments the index.
  - index == latched entries → DONE; otherwise → FETCH.
  - Index width is ROM_AW+1, so a full 2^ROM_AW table does not wrap.
- DONE sets init_done=1 and busy=0.
- ERROR sets init_error=1, busy=0, err_index=current index.
- The FSM has no NACK report. A NACKed write appears only as a verify mismatch, and a NACKed read returns the FSM's stale data_receive (verify then fails).

Test Plan:
- 3-entry table {0x12=0x80 skip_verify}, {0xFF=0x02}, {0x11=0x01}, PWRUP_CYCLES=10, behavioural sccb_fsm model (done 100 cycles after valid, echoes writes) → exactly 3 sccb_valid pulses, ordered write 0x12, write 0x11, read 0x11. Gap before the write to 0x11 is ≥2000 cycles. init_done=1, init_error=0.
- Model returns 0x00 for a read of 0x11 (wdata 0x01), MAX_RETRY=3 → 4 writes + 4 reads to 0x11, then init_error=1, err_index=2, busy=0.
- Model returns the wrong value once, then the correct value → exactly 2 writes + 2 reads to 0x11, init_done=1.
- Model never asserts sccb_done → init_error=1 exactly TIMEOUT_CYCLES cycles after sccb_valid, with err_index equal to the stuck entry.
- rom_entries=0 → no sccb_valid; init_done=1 PWRUP_CYCLES+1 cycles after start. start pulsed while busy=1 → ignored, no index reset.
- rstn asserted during WAIT → all outputs return to 0 immediately. A later start reruns the sequence from index 0.
